star_pkt_fifo: RTL and testbench

- Store-and-forward packet FIFO that sits directly upstream of a star arbiter's src port.
- It presents a packet downstream only once the whole packet is buffered, so the arbiter never holds its selection (and the star) while waiting on a slow source mid-packet.
- Packets longer than the buffer fall back to cut-through to avoid deadlock.
- AXI-Stream in, AXI-Stream out; TDATA+TLAST only.

---
 rtl/star_pkt_fifo.sv | 98 +++++++++
 tb/tb_star_pkt_fifo.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/star_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO feeding a star arbiter source port.
// A packet is only offered downstream once its TLAST flit is buffered; oversize packets fall back to cut-through.
module star_pkt_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_TDATA,
  input  logic                  in_TVALID,
  output logic                  in_TREADY,
  input  logic                  in_TLAST,
  output logic [DATA_WIDTH-1:0] out_TDATA,
  output logic                  out_TVALID,
  input  logic                  out_TREADY,
  output logic                  out_TLAST,
  output logic [DEPTH_LOG2:0]   occupancy,
  output logic [DEPTH_LOG2:0]   pkt_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] ONE = {{(PW-1){1'b0}}, 1'b1};

  // Each entry is {TLAST, TDATA}; contents are never reset.
  logic [DATA_WIDTH:0] mem [DEPTH];

  logic [PW-1:0]       wr_ptr_reg;
  logic [PW-1:0]       rd_ptr_reg;
  logic [PW-1:0]       pkt_count_reg;
  logic                rst_q_reg;
  logic                cut_reg;

  logic                full;
  logic                empty;
  logic                in_acc;
  logic                out_acc;
  logic                in_last_acc;
  logic                out_last_acc;
  logic [DATA_WIDTH:0] rd_word;

  assign full  = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                 (wr_ptr_reg[PW-2:0] == rd_ptr_reg[PW-2:0]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);

  // Ready and valid are functions of registered state only, so no
  // combinational path exists between the two handshakes.
  assign in_TREADY  = !rst_q_reg && !full;
  assign out_TVALID = !empty && ((pkt_count_reg != '0) || cut_reg);

  assign rd_word   = mem[rd_ptr_reg[PW-2:0]];
  assign out_TDATA = rd_word[DATA_WIDTH-1:0];
  assign out_TLAST = rd_word[DATA_WIDTH];

  assign in_acc       = in_TVALID && in_TREADY;
  assign out_acc      = out_TVALID && out_TREADY;
  assign in_last_acc  = in_acc && in_TLAST;
  assign out_last_acc = out_acc && rd_word[DATA_WIDTH];

  assign occupancy = wr_ptr_reg - rd_ptr_reg;
  assign pkt_count = pkt_count_reg;

  always_ff @(posedge clk) begin
    if (in_acc) begin
      mem[wr_ptr_reg[PW-2:0]] <= {in_TLAST, in_TDATA};
    end
  end

  always_ff @(posedge clk) begin
    rst_q_reg <= rst;
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      pkt_count_reg <= '0;
      cut_reg       <= 1'b0;
    end else begin
      if (in_acc) begin
        wr_ptr_reg <= wr_ptr_reg + ONE;
      end
      if (out_acc) begin
        rd_ptr_reg <= rd_ptr_reg + ONE;
      end
      case ({in_last_acc, out_last_acc})
        2'b10:   pkt_count_reg <= pkt_count_reg + ONE;
        2'b01:   pkt_count_reg <= pkt_count_reg - ONE;
        default: pkt_count_reg <= pkt_count_reg;
      endcase
      // A buffer filled by a single partial packet would never drain; switch
      // to cut-through until that packet's TLAST leaves. Clear has priority.
      if (out_last_acc && cut_reg) begin
        cut_reg <= 1'b0;
      end else if (full && (pkt_count_reg == '0)) begin
        cut_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_star_pkt_fifo.sv
// Self-checking bench for star_pkt_fifo (8-deep, 16-bit data) against a queue-based
// packet model; directed scenarios followed by randomized traffic over several wraps.
module tb_star_pkt_fifo;

  localparam int DW = 16;
  localparam int DL = 3;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in_TDATA;
  logic          in_TVALID;
  logic          in_TREADY;
  logic          in_TLAST;
  logic [DW-1:0] out_TDATA;
  logic          out_TVALID;
  logic          out_TREADY;
  logic          out_TLAST;
  logic [DL:0]   occupancy;
  logic [DL:0]   pkt_count;

  star_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_TDATA   (in_TDATA),
    .in_TVALID  (in_TVALID),
    .in_TREADY  (in_TREADY),
    .in_TLAST   (in_TLAST),
    .out_TDATA  (out_TDATA),
    .out_TVALID (out_TVALID),
    .out_TREADY (out_TREADY),
    .out_TLAST  (out_TLAST),
    .occupancy  (occupancy),
    .pkt_count  (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the buffered flits as {last, data}, plus cut-through mode.
  logic [DW:0] mq[$];
  logic [DW:0] out_log[$];
  int          out_cyc[$];
  logic [DW:0] flits[$];
  bit          m_cut = 1'b0;
  bit          m_rstq = 1'b1;
  bit          in_acc;
  bit          out_acc;
  bit          stall_seen;
  bit          cutvis_seen;
  int          cyc = 0;
  int          last_in_cyc = 0;
  int          max_occ = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: compare DUT against the model mid-cycle, then advance the model
  // by whatever handshakes the model says complete at the coming edge.
  task automatic cycle();
    int   tl;
    bit   exp_ready;
    bit   exp_valid;
    bit   new_cut;
    logic [DW:0] f;
    @(negedge clk);
    cyc++;
    tl = 0;
    foreach (mq[i]) if (mq[i][DW]) tl++;
    exp_ready = !m_rstq && (mq.size() < DEPTH);
    exp_valid = (mq.size() != 0) && ((tl != 0) || m_cut);
    check("occupancy", 32'(occupancy), mq.size());
    check("pkt_count", 32'(pkt_count), tl);
    check("in_TREADY", 32'(in_TREADY), 32'(exp_ready));
    check("out_TVALID", 32'(out_TVALID), 32'(exp_valid));
    if (exp_valid) begin
      check("out_TDATA", 32'(out_TDATA), 32'(mq[0][DW-1:0]));
      check("out_TLAST", 32'(out_TLAST), 32'(mq[0][DW]));
    end
    if (32'(occupancy) > max_occ) max_occ = 32'(occupancy);
    if (in_TVALID && !in_TREADY && occupancy == 4'd8) stall_seen = 1'b1;
    if (out_TVALID && pkt_count == 4'd0) cutvis_seen = 1'b1;
    in_acc  = !rst && in_TVALID && exp_ready;
    out_acc = !rst && exp_valid && out_TREADY;
    if (rst) begin
      mq.delete();
      m_cut = 1'b0;
    end else begin
      new_cut = m_cut;
      if (mq.size() == DEPTH && tl == 0) new_cut = 1'b1;
      if (out_acc && mq[0][DW] && m_cut) new_cut = 1'b0;
      if (out_acc) begin
        f = mq.pop_front();
        out_log.push_back(f);
        out_cyc.push_back(cyc);
      end
      if (in_acc) begin
        mq.push_back({in_TLAST, in_TDATA});
        last_in_cyc = cyc;
      end
      m_cut = new_cut;
    end
    m_rstq = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic send_flit(input logic [DW-1:0] d, input logic l);
    int t;
    in_TVALID = 1'b1;
    in_TDATA  = d;
    in_TLAST  = l;
    t = 0;
    do begin
      cycle();
      t++;
    end while (!in_acc && t < 200);
    if (!in_acc) check("send_timeout", 32'(in_acc), 32'd1);
    in_TVALID = 1'b0;
  endtask

  task automatic drain();
    int t;
    out_TREADY = 1'b1;
    t = 0;
    while (mq.size() != 0 && t < 500) begin
      cycle();
      t++;
    end
    check("drain_left", mq.size(), 32'd0);
  endtask

  initial begin
    int idx;
    int t;
    int len;
    rst        = 1'b1;
    in_TVALID  = 1'b0;
    in_TDATA   = '0;
    in_TLAST   = 1'b0;
    out_TREADY = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    check("rst_in_TREADY", 32'(in_TREADY), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_out_TVALID", 32'(out_TVALID), 32'd0);
    cycle();
    $display("reset released: in_TREADY=%0d", in_TREADY);

    // 4-flit packet, store-and-forward latency then back-to-back drain.
    out_TREADY = 1'b1;
    out_log.delete();
    out_cyc.delete();
    for (int i = 0; i < 4; i++) send_flit(16'hD000 + 16'(i), i == 3);
    drain();
    check("t1_count", out_log.size(), 32'd4);
    if (out_log.size() == 4) begin
      check("t1_first_cycle", out_cyc[0], last_in_cyc + 1);
      check("t1_consecutive", out_cyc[3], out_cyc[0] + 3);
    end
    $display("t1: 4-flit packet forwarded, %0d flits out", out_log.size());

    // Three 2-flit packets held back, then released.
    out_TREADY = 1'b0;
    out_log.delete();
    for (int i = 0; i < 6; i++) send_flit(16'hA000 + 16'(i), i[0]);
    cycle();
    check("t2_pkt_count", 32'(pkt_count), 32'd3);
    check("t2_occupancy", 32'(occupancy), 32'd6);
    check("t2_in_TREADY", 32'(in_TREADY), 32'd1);
    drain();
    check("t2_count", out_log.size(), 32'd6);
    for (int i = 0; i < out_log.size(); i++) begin
      check("t2_order", 32'(out_log[i]), {15'd0, i[0], 16'hA000 + 16'(i)});
    end
    $display("t2: 3 packets buffered and released, %0d flits out", out_log.size());

    // 12-flit packet overflows the 8-deep buffer: cut-through.
    out_log.delete();
    stall_seen  = 1'b0;
    cutvis_seen = 1'b0;
    for (int i = 0; i < 12; i++) send_flit(16'hC000 + 16'(i), i == 11);
    drain();
    check("t3_stall", 32'(stall_seen), 32'd1);
    check("t3_cut_visible", 32'(cutvis_seen), 32'd1);
    check("t3_count", out_log.size(), 32'd12);
    if (out_log.size() == 12) check("t3_last", 32'(out_log[11]), {15'd0, 1'b1, 16'hC00B});
    send_flit(16'hC100, 1'b0);
    send_flit(16'hC101, 1'b0);
    cycle();
    cycle();
    check("t3_cut_cleared", 32'(out_TVALID), 32'd0);
    send_flit(16'hC102, 1'b1);
    drain();
    $display("t3: oversize packet cut through, %0d flits out", out_log.size());

    // Same-cycle TLAST in and TLAST out with one packet buffered.
    out_TREADY = 1'b0;
    send_flit(16'hB001, 1'b1);
    cycle();
    check("t4_pre_pkt", 32'(pkt_count), 32'd1);
    in_TVALID  = 1'b1;
    in_TDATA   = 16'hB002;
    in_TLAST   = 1'b1;
    out_TREADY = 1'b1;
    cycle();
    in_TVALID  = 1'b0;
    out_TREADY = 1'b0;
    check("t4_both_acc", 32'(in_acc && out_acc), 32'd1);
    check("t4_pkt_count", 32'(pkt_count), 32'd1);
    check("t4_occupancy", 32'(occupancy), 32'd1);
    check("t4_head", 32'(out_TDATA), 32'h0000B002);
    drain();
    $display("t4: simultaneous TLAST in/out handled");

    // Random traffic: 40 packets, random valid/ready.
    flits.delete();
    out_log.delete();
    max_occ = 0;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) flits.push_back({i == len - 1, 16'($urandom)});
    end
    idx = 0;
    t = 0;
    while ((idx < flits.size() || mq.size() != 0) && t < 20000) begin
      out_TREADY = ($urandom_range(0, 3) != 0) || (idx >= flits.size());
      if (idx < flits.size() && $urandom_range(0, 3) != 0) begin
        in_TVALID = 1'b1;
        {in_TLAST, in_TDATA} = flits[idx];
      end else begin
        in_TVALID = 1'b0;
      end
      cycle();
      if (in_acc) idx++;
      t++;
    end
    in_TVALID = 1'b0;
    check("t5_count", out_log.size(), flits.size());
    for (int i = 0; i < out_log.size() && i < flits.size(); i++) begin
      check("t5_stream", 32'(out_log[i]), 32'(flits[i]));
    end
    check("t5_max_occ_le8", 32'(max_occ <= 8), 32'd1);
    $display("t5: %0d random flits streamed in %0d cycles, max occupancy %0d", flits.size(), t, max_occ);

    // Reset in the middle of a partial packet.
    out_TREADY = 1'b1;
    for (int i = 0; i < 3; i++) send_flit(16'hE000 + 16'(i), 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t6_occupancy", 32'(occupancy), 32'd0);
    check("t6_pkt_count", 32'(pkt_count), 32'd0);
    check("t6_out_TVALID", 32'(out_TVALID), 32'd0);
    check("t6_in_TREADY_low", 32'(in_TREADY), 32'd0);
    cycle();
    check("t6_in_TREADY_high", 32'(in_TREADY), 32'd1);
    out_log.delete();
    send_flit(16'hE0FF, 1'b1);
    drain();
    check("t6_count", out_log.size(), 32'd1);
    if (out_log.size() == 1) check("t6_flit", 32'(out_log[0]), {15'd0, 1'b1, 16'hE0FF});
    $display("t6: mid-packet reset discarded partial packet, %0d flit out", out_log.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
